fractal_sync_neighbor_mp: RTL



---
 rtl/fractal_sync_neighbor_mp_pkg.sv | 37 +++
 rtl/fractal_sync_neighbor_mp_if.sv | 24 ++
 rtl/fractal_sync_neighbor_mp_timeout.sv | 28 ++
 rtl/fractal_sync_neighbor_mp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_neighbor_mp_pkg.sv
// Shared types for the multi-port neighbor sync node: default request/response
// templates, the FSM state enum and the timer width helper.
package fractal_sync_neighbor_mp_pkg;

  localparam int DFLT_ID_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    WAKE,
    ABORT
  } fsync_nbr_state_e;

  typedef struct packed {
    logic                 lvl;
    logic [DFLT_ID_W-1:0] id;
  } fsync_nbr_sig_t;

  typedef struct packed {
    logic           sync;
    fsync_nbr_sig_t sig;
  } fsync_nbr_req_t;

  typedef struct packed {
    logic           wake;
    fsync_nbr_sig_t sig;
    logic           error;
  } fsync_nbr_rsp_t;

  // Saturating timer width: enough to hold TIMEOUT, never less than one bit.
  function automatic int tmr_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fractal_sync_neighbor_mp_if.sv
// Per-port request/response bundle of the multi-port neighbor sync node.
interface fractal_sync_neighbor_mp_if #(
  parameter int  N_PORTS     = 2,
  parameter type fsync_req_t = fractal_sync_neighbor_mp_pkg::fsync_nbr_req_t,
  parameter type fsync_rsp_t = fractal_sync_neighbor_mp_pkg::fsync_nbr_rsp_t
);

  fsync_req_t [N_PORTS-1:0] req_i;
  fsync_rsp_t [N_PORTS-1:0] rsp_o;
  logic                     busy_o;

  modport master (
    output req_i,
    input  rsp_o,
    input  busy_o
  );

  modport slave (
    input  req_i,
    output rsp_o,
    output busy_o
  );

endinterface

// File: rtl/fractal_sync_neighbor_mp_timeout.sv
// Saturating gather timer: cleared on demand, counts while enabled, and flags
// the last cycle allowed before the barrier is aborted.
module fractal_sync_nbr_timeout #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_hit = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fractal_sync_neighbor_mp.sv
// N-port neighbor barrier: gathers sync arrivals carrying a common id, wakes all
// ports when complete, flags id mismatches/duplicates and aborts on timeout.
module fractal_sync_neighbor_mp
  import fractal_sync_neighbor_mp_pkg::*;
#(
  parameter type  fsync_req_t = fractal_sync_neighbor_mp_pkg::fsync_nbr_req_t,
  parameter type  fsync_rsp_t = fractal_sync_neighbor_mp_pkg::fsync_nbr_rsp_t,
  parameter int   N_PORTS     = 2,
  parameter int   ID_W        = 2,
  parameter int   TIMEOUT     = 0,
  parameter logic COMB        = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  fractal_sync_neighbor_mp_if.slave     nbr
);

  localparam int TMR_W = tmr_width(TIMEOUT);

  fsync_req_t [N_PORTS-1:0] w_req;
  fsync_rsp_t [N_PORTS-1:0] w_rsp;

  fsync_nbr_state_e   r_state, w_state_d;
  logic [N_PORTS-1:0] r_presence, w_presence_d;
  logic [N_PORTS-1:0] r_err, w_err_d;
  logic [ID_W-1:0]    r_id, w_id_d, w_ref_id, r_rsp_id;
  logic               r_wake, w_wake_d;
  logic               w_any_sync;
  logic               w_tmr_en, w_tmr_clr, w_tmr_hit;
  logic               w_unused_lvl;

  assign w_req      = nbr.req_i;
  assign nbr.rsp_o  = w_rsp;
  assign nbr.busy_o = (r_state == GATHER);

  // Request levels carry no information for a neighbor node.
  always_comb begin
    w_unused_lvl = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_unused_lvl = w_unused_lvl ^ w_req[i].sig.lvl;
    end
  end

  // Reference id for a new barrier: lowest-indexed port raising sync.
  always_comb begin
    w_ref_id   = '0;
    w_any_sync = 1'b0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (w_req[i].sync) begin
        w_ref_id   = w_req[i].sig.id;
        w_any_sync = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_presence_d = r_presence;
    w_id_d       = r_id;
    w_err_d      = '0;
    w_wake_d     = 1'b0;
    w_tmr_en     = 1'b0;
    w_tmr_clr    = 1'b0;

    case (r_state)
      GATHER: begin
        w_tmr_en = 1'b1;
        for (int i = 0; i < N_PORTS; i++) begin
          if (w_req[i].sync) begin
            if ((w_req[i].sig.id != r_id) || r_presence[i]) begin
              w_err_d[i] = 1'b1;
            end else begin
              w_presence_d[i] = 1'b1;
            end
          end
        end
        if (&w_presence_d) begin
          w_state_d    = WAKE;
          w_wake_d     = 1'b1;
          w_presence_d = '0;
          w_tmr_clr    = 1'b1;
        end else if (w_tmr_hit) begin
          w_state_d    = ABORT;
          w_err_d      = w_err_d | w_presence_d;
          w_presence_d = '0;
          w_tmr_clr    = 1'b1;
        end
      end

      default: begin
        // IDLE, WAKE and ABORT all accept the start of a fresh barrier.
        w_presence_d = '0;
        w_tmr_clr    = 1'b1;
        if (w_any_sync) begin
          w_id_d = w_ref_id;
        end
        for (int i = 0; i < N_PORTS; i++) begin
          if (w_req[i].sync) begin
            if (w_req[i].sig.id == w_ref_id) begin
              w_presence_d[i] = 1'b1;
            end else begin
              w_err_d[i] = 1'b1;
            end
          end
        end
        if (&w_presence_d) begin
          w_state_d    = WAKE;
          w_wake_d     = 1'b1;
          w_presence_d = '0;
        end else if (|w_presence_d) begin
          w_state_d = GATHER;
        end else begin
          w_state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_presence <= '0;
      r_id       <= '0;
      r_err      <= '0;
      r_wake     <= 1'b0;
      r_rsp_id   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_presence <= w_presence_d;
      r_id       <= w_id_d;
      r_err      <= w_err_d;
      r_wake     <= w_wake_d;
      r_rsp_id   <= w_wake_d ? w_id_d : '0;
    end
  end

  // Combinational responses are gated by reset so nothing leaks out while held.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      w_rsp[i]         = '0;
      w_rsp[i].sig.lvl = 1'b1;
      if (COMB) begin
        w_rsp[i].wake   = w_wake_d & rst_ni;
        w_rsp[i].sig.id = (w_wake_d && rst_ni) ? w_id_d : '0;
        w_rsp[i].error  = w_err_d[i] & rst_ni;
      end else begin
        w_rsp[i].wake   = r_wake;
        w_rsp[i].sig.id = r_rsp_id;
        w_rsp[i].error  = r_err[i];
      end
    end
  end

  generate
    if (TIMEOUT != 0) begin : g_timeout
      fractal_sync_nbr_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (TMR_W)
      ) u_timeout (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_clr  (w_tmr_clr),
        .i_en   (w_tmr_en),
        .o_hit  (w_tmr_hit)
      );
    end else begin : g_no_timeout
      logic w_unused_tmr;
      assign w_unused_tmr = w_tmr_en ^ w_tmr_clr;
      assign w_tmr_hit    = 1'b0;
    end
  endgenerate

endmodule
